logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's combinational two-input gate block.
- Applies one of eight bitwise logic functions to WIDTH-bit operands, selected per transaction by opcode.
- Optional accumulate mode replaces operand B with the running result.
- Valid/ready handshake, 1-cycle registered latency; sits between a stimulus/control source and downstream datapath logic.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 16, width of the accepted-operation counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  block can accept a transaction this cycle
- op  input  3  function select
- acc_mode  input  1  1: operand B = accumulator, in_b ignored
- acc_clr  input  1  synchronous accumulator clear
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  registered result
- op_count  output  CNT_W  number of accepted transactions, saturating

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, accumulator=0, op_count=0. in_ready=1 immediately after reset is released.
- Opcodes:
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 NOT: ~A (B ignored)
  - 3 NAND: ~(A&B)
  - 4 NOR: ~(A|B)
  - 5 XOR: A^B
  - 6 XNOR: ~(A^B)
  - 7 PASS: A
- All functions are full-width bitwise; no carries; no width growth.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single output stage).
  - Accept = in_valid && in_ready.
  - in_* and op must be held stable while in_valid=1 && in_ready=0.
- On accept, next edge: out_data <= f(A,B), out_valid <= 1. Latency is exactly 1 cycle.
- Output hold: out_valid=1 && out_ready=0 holds out_data and out_valid unchanged; in_ready=0.
- Output drain: out_ready=1 with no accept drops out_valid to 0 next edge.
- Simultaneous output drain and accept: new result loaded, out_valid stays 1. Sustains one transaction per cycle.
- Operand B on each accept:
  - acc_mode=0: B = in_b.
  - acc_mode=1: B = accumulator, or 0 if acc_clr=1 in the same cycle.
- Accumulator update, evaluated every edge:
  - accept: acc <= result (either acc_mode).
  - acc_clr=1 without accept: acc <= 0.
  - otherwise: hold.
- op_count increments by 1 on each accept and saturates at 2^CNT_W-1. Cleared only by reset.
- Reset mid-transaction: pending out_data is discarded, out_valid=0 asynchronously, and no partial result survives.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- Defined: adds three output ports, all registered alongside out_data, updated on the same edge, held with it, and reset to 0:
  - flag_zero, 1 bit: result == 0
  - flag_ones, 1 bit: result == all ones
  - flag_parity, 1 bit: XOR-reduction of result
- Not defined: ports absent, no flag logic synthesised; all other behaviour identical.

Test Plan:
- Gate sweep, WIDTH=8, out_ready=1, acc_mode=0, A=0xCC, B=0xAA, op 0..7 in consecutive cycles -> out_data one cycle later: 0x88, 0xEE, 0x33, 0x77, 0x11, 0x66, 0x99, 0xCC; out_valid continuous 8 cycles; op_count=8.
- Backpressure: out_ready=0 after first accept, in_valid held with op=1, A=0x0F, B=0xF0 -> in_ready=0, first out_data held stable for 4 cycles; out_ready=1 -> 0xFF appears next cycle, no transaction lost or duplicated.
- Accumulate, all with acc_mode=1:
  - acc_clr=1, op=1, A=0x01 -> 0x01
  - then op=1, A=0x02 -> 0x03
  - then op=5, A=0xFF -> 0xFC
  - then acc_clr=1, op=1, A=0x10 -> 0x10 (cleared B)
- Async reset mid-stream: rst_n low for 3ns between edges while out_valid=1 -> out_valid, out_data, op_count drop to 0 immediately; first post-reset acc_mode op=1, A=0x05 -> 0x05.
- Counter saturation, CNT_W=3: 10 accepts -> op_count reaches 7 and stays 7.
- LOGIC_UNIT_FLAGS_EN defined:
  - op=0, A=0xF0, B=0x0F -> flag_zero=1, flag_ones=0, flag_parity=0
  - op=4, A=0, B=0 -> flag_ones=1, flag_parity=0
  - op=7, A=0x07 -> flag_parity=1

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered 8-function bitwise logic unit with accumulate.
// Optional flag outputs enabled by defining LOGIC_UNIT_FLAGS_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_parity
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] result;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Same-cycle clear wins over the stored accumulator value.
    assign opb = acc_mode ? (acc_clr ? '0 : acc) : in_b;

    // Function select.
    always_comb begin
        result = '0;
        unique case (op)
            3'd0: result = in_a & opb;
            3'd1: result = in_a | opb;
            3'd2: result = ~in_a;
            3'd3: result = ~(in_a & opb);
            3'd4: result = ~(in_a | opb);
            3'd5: result = in_a ^ opb;
            3'd6: result = ~(in_a ^ opb);
            3'd7: result = in_a;
        endcase
    end

    // Single output stage: load on accept, drain when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator tracks the last accepted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= result;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    // Saturating count of accepted transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept && op_count != CNT_MAX) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // Result flags travel with out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_zero   <= 1'b0;
            flag_ones   <= 1'b0;
            flag_parity <= 1'b0;
        end else if (accept) begin
            flag_zero   <= (result == '0);
            flag_ones   <= &result;
            flag_parity <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed checks for logic_unit_pipe.
// Second instance with CNT_W=3 shares stimulus to exercise counter saturation.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic       acc_mode;
    logic       acc_clr;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [15:0] op_count;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic [2:0] s_op_count;

`ifdef LOGIC_UNIT_FLAGS_EN
    logic flag_zero, flag_ones, flag_parity;
    logic s_fz, s_fo, s_fp;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .op_count(op_count)
`ifdef LOGIC_UNIT_FLAGS_EN
        , .flag_zero(flag_zero), .flag_ones(flag_ones),
        .flag_parity(flag_parity)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .in_a(in_a), .in_b(in_b),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .op_count(s_op_count)
`ifdef LOGIC_UNIT_FLAGS_EN
        , .flag_zero(s_fz), .flag_ones(s_fo), .flag_parity(s_fp)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        op       = o;
        in_a     = a;
        in_b     = b;
    endtask

    logic [7:0] sweep [8];

    initial begin
        sweep = '{8'h88, 8'hEE, 8'h33, 8'h77, 8'h11, 8'h66, 8'h99, 8'hCC};
        rst_n = 1'b0;
        out_ready = 1'b1;
        acc_mode = 1'b0;
        acc_clr = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Gate sweep
        @(negedge clk);
        drive(1'b1, 3'd0, 8'hCC, 8'hAA);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("sweep_valid_%0d", i - 1), out_valid, 1);
            chk($sformatf("sweep_data_%0d", i - 1), out_data, sweep[i-1]);
            if (i < 8) drive(1'b1, 3'(i), 8'hCC, 8'hAA);
            else in_valid = 1'b0;
        end
        chk("sweep_count", op_count, 8);
        chk("sat_count_8", s_op_count, 7);
        @(negedge clk);
        chk("drain_valid", out_valid, 0);

        // Backpressure
        drive(1'b1, 3'd7, 8'h3C, 8'h00);
        @(negedge clk);
        chk("bp_first", out_data, 8'h3C);
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h0F, 8'hF0);
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data_%0d", i), out_data, 8'h3C);
            chk($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
            chk($sformatf("bp_hold_rdy_%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", out_data, 8'hFF);
        chk("bp_rel_valid", out_valid, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain", out_valid, 0);
        chk("bp_count", op_count, 10);
        chk("sat_count_10", s_op_count, 7);

        // Accumulate
        acc_mode = 1'b1;
        acc_clr = 1'b1;
        drive(1'b1, 3'd1, 8'h01, 8'h55);
        @(negedge clk);
        chk("acc_clr_or", out_data, 8'h01);
        acc_clr = 1'b0;
        drive(1'b1, 3'd1, 8'h02, 8'h55);
        @(negedge clk);
        chk("acc_or", out_data, 8'h03);
        drive(1'b1, 3'd5, 8'hFF, 8'h55);
        @(negedge clk);
        chk("acc_xor", out_data, 8'hFC);
        acc_clr = 1'b1;
        drive(1'b1, 3'd1, 8'h10, 8'h55);
        @(negedge clk);
        chk("acc_clr2", out_data, 8'h10);
        acc_clr = 1'b0;
        acc_mode = 1'b0;
        in_valid = 1'b0;

        // Async reset mid-stream
        @(negedge clk);
        drive(1'b1, 3'd7, 8'h5A, 8'h00);
        @(negedge clk);
        chk("pre_rst_data", out_data, 8'h5A);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_count", op_count, 0);
        chk("arst_sat_count", s_op_count, 0);
`ifdef LOGIC_UNIT_FLAGS_EN
        chk("arst_flags", {flag_zero, flag_ones, flag_parity}, 0);
`endif
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b1;
        acc_mode = 1'b1;
        drive(1'b1, 3'd1, 8'h05, 8'hAA);
        @(negedge clk);
        chk("post_rst_acc", out_data, 8'h05);
        acc_mode = 1'b0;

        // Saturation on CNT_W=3 instance
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd7, 8'(i + 8'h20), 8'h00);
            @(negedge clk);
            chk($sformatf("sat_data_%0d", i), out_data, i + 8'h20);
            chk($sformatf("main_cnt_%0d", i), op_count, i + 2);
            chk($sformatf("sat_cnt_%0d", i), s_op_count,
                (i + 2 > 7) ? 7 : i + 2);
        end
        in_valid = 1'b0;

`ifdef LOGIC_UNIT_FLAGS_EN
        drive(1'b1, 3'd0, 8'hF0, 8'h0F);
        @(negedge clk);
        chk("flag_and", {flag_zero, flag_ones, flag_parity}, 3'b100);
        drive(1'b1, 3'd4, 8'h00, 8'h00);
        @(negedge clk);
        chk("flag_nor", {flag_zero, flag_ones, flag_parity}, 3'b010);
        drive(1'b1, 3'd7, 8'h07, 8'h00);
        @(negedge clk);
        chk("flag_pass", {flag_zero, flag_ones, flag_parity}, 3'b001);
        in_valid = 1'b0;
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
